// File: rtl/fake_psx_pad.sv
// ============================================================================
// Module   : fake_psx_pad
// Purpose  : Device-side PSX digital pad model answering a host poll.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fake_psx_pad #(
    parameter int unsigned ACK_DELAY = 20,
    parameter int unsigned ACK_WIDTH = 4,
    parameter logic [7:0]  PAD_ID    = 8'h41
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        att,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic        poll_done
);

    localparam logic [15:0] c_ack_dly = (ACK_DELAY == 0) ? 16'd1 : 16'(ACK_DELAY);
    localparam logic [15:0] c_ack_wid = (ACK_WIDTH == 0) ? 16'd1 : 16'(ACK_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_ACK_WAIT  = 3'd2,
        ST_ACK_PULSE = 3'd3,
        ST_IGNORE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        att_meta_q, att_sync_q, att_prev_q;
    logic        pclk_meta_q, pclk_sync_q, pclk_prev_q;
    logic        cmd_meta_q, cmd_sync_q;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        done_q, done_d;
    logic [7:0]  rx_q, rx_d;
    logic [15:0] btn_lat_q, btn_lat_d;
    logic [15:0] cnt_q, cnt_d;
    logic        data_q, data_d;
    logic        ack_q, ack_d;
    logic        poll_done_q, poll_done_d;

    logic        w_att_fall, w_att_rise, w_pclk_fall, w_pclk_rise, w_last_rise;
    logic [7:0]  w_reply, w_reply_next;

    function automatic logic [7:0] reply_byte(input logic [2:0] idx, input logic [15:0] lat);
        case (idx)
            3'd0:    reply_byte = 8'hFF;
            3'd1:    reply_byte = PAD_ID;
            3'd2:    reply_byte = 8'h5A;
            3'd3:    reply_byte = lat[7:0];
            3'd4:    reply_byte = lat[15:8];
            default: reply_byte = 8'hFF;
        endcase
    endfunction

    assign w_att_fall   = att_prev_q & ~att_sync_q;
    assign w_att_rise   = ~att_prev_q & att_sync_q;
    assign w_pclk_fall  = pclk_prev_q & ~pclk_sync_q;
    assign w_pclk_rise  = ~pclk_prev_q & pclk_sync_q;
    assign w_reply      = reply_byte(byte_idx_q, btn_lat_q);
    assign w_reply_next = reply_byte(byte_idx_q + 3'd1, btn_lat_q);
    assign w_last_rise  = (state_q == ST_SHIFT) && w_pclk_rise && (bit_cnt_q == 3'd7) && !done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            att_meta_q  <= 1'b1;
            att_sync_q  <= 1'b1;
            att_prev_q  <= 1'b1;
            pclk_meta_q <= 1'b1;
            pclk_sync_q <= 1'b1;
            pclk_prev_q <= 1'b1;
            cmd_meta_q  <= 1'b0;
            cmd_sync_q  <= 1'b0;
            state_q     <= ST_IDLE;
            byte_idx_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            done_q      <= 1'b0;
            rx_q        <= 8'h00;
            btn_lat_q   <= 16'hFFFF;
            cnt_q       <= 16'd0;
            data_q      <= 1'b1;
            ack_q       <= 1'b1;
            poll_done_q <= 1'b0;
        end else begin
            att_meta_q  <= att;
            att_sync_q  <= att_meta_q;
            att_prev_q  <= att_sync_q;
            pclk_meta_q <= psx_clk;
            pclk_sync_q <= pclk_meta_q;
            pclk_prev_q <= pclk_sync_q;
            cmd_meta_q  <= cmd;
            cmd_sync_q  <= cmd_meta_q;
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= done_d;
            rx_q        <= rx_d;
            btn_lat_q   <= btn_lat_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            poll_done_q <= poll_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        bit_cnt_d   = bit_cnt_q;
        done_d      = done_q;
        rx_d        = rx_q;
        btn_lat_d   = btn_lat_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        ack_d       = ack_q;
        poll_done_d = 1'b0;

        if ((state_q != ST_IDLE) && w_att_rise) begin
            // A poll whose last byte lands together with the att release still counts.
            poll_done_d = (byte_idx_q == 3'd4) &&
                          (w_last_rise || ((state_q == ST_SHIFT) && done_q));
            state_d     = ST_IDLE;
            data_d      = 1'b1;
            ack_d       = 1'b1;
            byte_idx_d  = 3'd0;
            bit_cnt_d   = 3'd0;
            done_d      = 1'b0;
            cnt_d       = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                    if (w_att_fall) begin
                        state_d    = ST_SHIFT;
                        byte_idx_d = 3'd0;
                        bit_cnt_d  = 3'd0;
                        done_d     = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (done_q) begin
                        done_d = 1'b0;
                        data_d = 1'b1;
                        if ((byte_idx_q == 3'd0) && (rx_q != 8'h01)) begin
                            state_d = ST_IGNORE;
                        end else if ((byte_idx_q == 3'd1) && (rx_q != 8'h42)) begin
                            state_d = ST_IGNORE;
                        end else if (byte_idx_q == 3'd4) begin
                            poll_done_d = 1'b1;
                            state_d     = ST_IGNORE;
                        end else begin
                            if (byte_idx_q == 3'd1) begin
                                btn_lat_d = buttons;
                            end
                            // The evaluation clock itself is the first delay clock.
                            if (c_ack_dly == 16'd1) begin
                                ack_d   = 1'b0;
                                cnt_d   = c_ack_wid - 16'd1;
                                state_d = ST_ACK_PULSE;
                            end else begin
                                cnt_d   = c_ack_dly - 16'd2;
                                state_d = ST_ACK_WAIT;
                            end
                        end
                    end else if (w_pclk_fall) begin
                        data_d = w_reply[bit_cnt_q];
                    end else if (w_pclk_rise) begin
                        rx_d[bit_cnt_q] = cmd_sync_q;
                        bit_cnt_d       = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_ACK_WAIT, ST_ACK_PULSE: begin
                    if (w_pclk_fall) begin
                        // Host did not wait for ack: this edge is bit 0 of the next byte.
                        ack_d      = 1'b1;
                        byte_idx_d = byte_idx_q + 3'd1;
                        bit_cnt_d  = 3'd0;
                        data_d     = w_reply_next[0];
                        state_d    = ST_SHIFT;
                    end else if (cnt_q != 16'd0) begin
                        cnt_d = cnt_q - 16'd1;
                    end else if (state_q == ST_ACK_WAIT) begin
                        ack_d   = 1'b0;
                        cnt_d   = c_ack_wid - 16'd1;
                        state_d = ST_ACK_PULSE;
                    end else begin
                        ack_d      = 1'b1;
                        byte_idx_d = byte_idx_q + 3'd1;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_SHIFT;
                    end
                end
                ST_IGNORE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign ack       = ack_q;
    assign poll_done = poll_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fake_psx_pad.sv
// ============================================================================
// Module   : tb_fake_psx_pad
// Purpose  : Host-side bench for fake_psx_pad with a reply-byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fake_psx_pad;

    logic        clk = 1'b0;
    logic        rst;
    logic        att;
    logic        psx_clk;
    logic        cmd;
    logic [15:0] buttons;
    logic        data;
    logic        ack;
    logic        poll_done;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pd_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] sw_val_g;

    // Pin rise -> 3 clocks through sync/edge detect, then ACK_DELAY clocks.
    localparam int c_ACK_LAT = 23;
    localparam int c_ACK_W   = 4;

    fake_psx_pad #(
        .ACK_DELAY (20),
        .ACK_WIDTH (4),
        .PAD_ID    (8'h41)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .att       (att),
        .psx_clk   (psx_clk),
        .cmd       (cmd),
        .buttons   (buttons),
        .data      (data),
        .ack       (ack),
        .poll_done (poll_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (poll_done === 1'b1) pd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge that drives the 8th rise.
    task automatic shift_byte(input logic [7:0] c, output logic [7:0] r);
        for (int i = 0; i < 8; i++) begin
            psx_clk = 1'b0;
            cmd     = c[i];
            wait_clks(6);
            r[i]    = data;
            psx_clk = 1'b1;
            if (i < 7) wait_clks(6);
        end
    endtask

    task automatic xfer(input string tag, input logic [7:0] c, input logic [7:0] e, input bit exp_ack);
        logic [7:0] r;
        int n, w;
        exp_q.push_back(e);
        shift_byte(c, r);
        chk(tag, {24'd0, r}, {24'd0, exp_q.pop_front()});
        n = 0;
        w = 0;
        if (exp_ack) begin
            while (n < 60 && ack !== 1'b0) begin
                @(negedge clk);
                n++;
            end
            while (ack === 1'b0 && w < 20) begin
                w++;
                @(negedge clk);
            end
            chk({tag, "_ack_dly"}, n, c_ACK_LAT);
            chk({tag, "_ack_w"}, w, c_ACK_W);
        end else begin
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (ack !== 1'b1) w++;
            end
            chk({tag, "_noack"}, w, 0);
        end
        wait_clks(3);
    endtask

    // Bytes/acks are listed left to right starting with byte 0.
    task automatic poll(input string tag, input logic [39:0] cmds, input logic [39:0] exps,
                        input logic [4:0] acks, input int pd_exp, input int sw_k);
        int pd0;
        pd0 = pd_cnt;
        att = 1'b0;
        wait_clks(6);
        for (int k = 0; k < 5; k++) begin
            if (k == sw_k) begin
                fork
                    begin
                        wait_clks(40);
                        buttons = sw_val_g;
                    end
                join_none
            end
            xfer($sformatf("%s_b%0d", tag, k), cmds[39-8*k -: 8], exps[39-8*k -: 8], acks[4-k]);
        end
        att = 1'b1;
        wait_clks(10);
        chk({tag, "_poll_done"}, pd_cnt - pd0, pd_exp);
    endtask

    initial begin
        logic [7:0] r;
        int pd0, n;

        rst     = 1'b1;
        att     = 1'b1;
        psx_clk = 1'b1;
        cmd     = 1'b0;
        buttons = 16'hFFFE;
        sw_val_g = 16'h0000;
        #1;
        chk("rst_data", {31'd0, data}, 1);
        chk("rst_ack", {31'd0, ack}, 1);
        chk("rst_poll_done", {31'd0, poll_done}, 0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(5);

        poll("full", 40'h01_42_00_00_00, 40'hFF_41_5A_FE_FF, 5'b11110, 1, 9);

        poll("badstart", 40'h81_42_00_00_00, 40'hFF_FF_FF_FF_FF, 5'b00000, 0, 9);
        poll("after_bad", 40'h01_42_00_00_00, 40'hFF_41_5A_FE_FF, 5'b11110, 1, 9);

        poll("badcmd", 40'h01_43_00_00_00, 40'hFF_41_FF_FF_FF, 5'b10000, 0, 9);

        buttons  = 16'h00FF;
        sw_val_g = 16'hFF00;
        poll("coher", 40'h01_42_00_00_00, 40'hFF_41_5A_FF_00, 5'b11110, 1, 2);
        poll("coher2", 40'h01_42_00_00_00, 40'hFF_41_5A_00_FF, 5'b11110, 1, 9);

        // Abort during byte 3 while a 0 bit is on the data line.
        buttons = 16'h0000;
        pd0 = pd_cnt;
        att = 1'b0;
        wait_clks(6);
        xfer("abort_b0", 8'h01, 8'hFF, 1'b1);
        xfer("abort_b1", 8'h42, 8'h41, 1'b1);
        xfer("abort_b2", 8'h00, 8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            psx_clk = 1'b0;
            wait_clks(6);
            psx_clk = 1'b1;
            wait_clks(6);
        end
        psx_clk = 1'b0;
        wait_clks(6);
        chk("abort_pre_data", {31'd0, data}, 0);
        att = 1'b1;
        wait_clks(3);
        chk("abort_data", {31'd0, data}, 1);
        chk("abort_ack", {31'd0, ack}, 1);
        psx_clk = 1'b1;
        wait_clks(10);
        chk("abort_poll_done", pd_cnt - pd0, 0);
        poll("after_abort", 40'h01_42_00_00_00, 40'hFF_41_5A_00_00, 5'b11110, 1, 9);

        // Reset while ack is low.
        buttons = 16'hFFFE;
        pd0 = pd_cnt;
        att = 1'b0;
        wait_clks(6);
        shift_byte(8'h01, r);
        n = 0;
        while (n < 60 && ack !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pulse_seen", {31'd0, ack}, 0);
        wait_clks(1);
        rst = 1'b1;
        att = 1'b1;
        #1;
        chk("rst_pulse_ack", {31'd0, ack}, 1);
        chk("rst_pulse_data", {31'd0, data}, 1);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(10);
        chk("rst_pulse_poll_done", pd_cnt - pd0, 0);
        poll("after_rst", 40'h01_42_00_00_00, 40'hFF_41_5A_FE_FF, 5'b11110, 1, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
